// File: rtl/jt10_adpcm_romarb_pkg.sv
// Shared types for the ADPCM ROM arbiter.
//   state_e   : arbiter FSM states (idle / ROM access in flight / strobe gap)
//   side_e    : requester identity (ADPCM-A or ADPCM-B)
//   pick_side : round-robin miss grant
package jt10_adpcm_romarb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  typedef enum logic {
    SIDE_A = 1'b0,
    SIDE_B = 1'b1
  } side_e;

  // Only one side missing gets the grant outright; a tie goes to the side
  // that was not granted last.
  function automatic side_e pick_side(input logic a_miss, input logic b_miss,
                                      input side_e last);
    side_e s;
    if (a_miss && b_miss) begin
      if (last == SIDE_B) s = SIDE_A;
      else                s = SIDE_B;
    end else if (a_miss) begin
      s = SIDE_A;
    end else begin
      s = SIDE_B;
    end
    return s;
  endfunction

endpackage

// File: rtl/jt10_adpcm_romarb_if.sv
// Bus bundle between the two ADPCM requesters, the arbiter and the ROM port.
//   a_req/a_addr -> a_data/a_ok  : ADPCM-A read channel
//   b_req/b_addr -> b_data/b_ok  : ADPCM-B read channel
//   rom_addr/rom_cs -> rom_data/rom_ok : shared ROM port
//   tout_err : sticky ROM timeout flag
// modport slave  : the arbiter side
// modport master : the environment (requesters + ROM)
interface jt10_adpcm_romarb_if #(
  parameter int unsigned AW = 24
);
  logic          a_req;
  logic [AW-1:0] a_addr;
  logic [7:0]    a_data;
  logic          a_ok;
  logic          b_req;
  logic [AW-1:0] b_addr;
  logic [7:0]    b_data;
  logic          b_ok;
  logic [AW-1:0] rom_addr;
  logic          rom_cs;
  logic [7:0]    rom_data;
  logic          rom_ok;
  logic          tout_err;

  modport slave (
    input  a_req, a_addr, b_req, b_addr, rom_data, rom_ok,
    output a_data, a_ok, b_data, b_ok, rom_addr, rom_cs, tout_err
  );

  modport master (
    output a_req, a_addr, b_req, b_addr, rom_data, rom_ok,
    input  a_data, a_ok, b_data, b_ok, rom_addr, rom_cs, tout_err
  );
endinterface

// File: rtl/jt10_adpcm_romarb_rdcache.sv
// One-entry read cache: remembers the last byte fetched from ROM for one
// requester and reports whether a lookup address matches it.
//   clk, rst : clock, synchronous active-high reset (invalidates the entry)
//   wr_en    : load wr_addr/wr_data and mark the entry valid
//   rd_addr  : lookup address (full-width compare)
//   hit      : entry valid and address matches
//   data     : cached byte
module jt10_adpcm_rdcache #(
  parameter int unsigned AW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic          hit,
  output logic [7:0]    data
);

  logic          valid_q, valid_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [7:0]    data_q,  data_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (wr_en) begin
      valid_d = 1'b1;
      addr_d  = wr_addr;
      data_d  = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign hit  = valid_q && (addr_q == rd_addr);
  assign data = data_q;

endmodule

// File: rtl/jt10_adpcm_romarb.sv
// Shares one ADPCM sample ROM port between the ADPCM-A and ADPCM-B engines.
// Each requester has a one-entry read cache so that the second nibble of a
// byte costs no ROM cycle; misses are granted round-robin.
//   clk, rst : clock, synchronous active-high reset
//   bus      : requester channels, ROM port and sticky tout_err (slave side)
// Parameters: AW address width, TOUT max BUSY cycles waiting for rom_ok.
module jt10_adpcm_romarb
  import jt10_adpcm_romarb_pkg::*;
#(
  parameter int unsigned AW   = 24,
  parameter int unsigned TOUT = 1023
) (
  input  logic                      clk,
  input  logic                      rst,
  jt10_adpcm_romarb_if.slave        bus
);

  localparam int unsigned    CW       = $clog2(TOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TOUT - 1);

  state_e        state_q,    state_d;
  side_e         rr_last_q,  rr_last_d;
  side_e         gnt_q,      gnt_d;
  logic          rom_cs_q,   rom_cs_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic          a_ok_q,     a_ok_d;
  logic [7:0]    a_data_q,   a_data_d;
  logic          b_ok_q,     b_ok_d;
  logic [7:0]    b_data_q,   b_data_d;
  logic          tout_err_q, tout_err_d;

  logic          a_chit, b_chit;
  logic [7:0]    a_cdata, b_cdata;
  logic          a_wr, b_wr;
  logic          a_hit, a_miss, b_hit, b_miss;
  side_e         pick;

  jt10_adpcm_rdcache #(.AW(AW)) u_cache_a (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (a_wr),
    .wr_addr (rom_addr_q),
    .wr_data (bus.rom_data),
    .rd_addr (bus.a_addr),
    .hit     (a_chit),
    .data    (a_cdata)
  );

  jt10_adpcm_rdcache #(.AW(AW)) u_cache_b (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (b_wr),
    .wr_addr (rom_addr_q),
    .wr_data (bus.rom_data),
    .rd_addr (bus.b_addr),
    .hit     (b_chit),
    .data    (b_cdata)
  );

  // A request still high during its own ok cycle is the one just served;
  // it only counts as a new request from the following cycle on.
  assign a_hit  = bus.a_req && !a_ok_q &&  a_chit;
  assign a_miss = bus.a_req && !a_ok_q && !a_chit;
  assign b_hit  = bus.b_req && !b_ok_q &&  b_chit;
  assign b_miss = bus.b_req && !b_ok_q && !b_chit;
  assign pick   = pick_side(a_miss, b_miss, rr_last_q);

  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    gnt_d      = gnt_q;
    rom_cs_d   = rom_cs_q;
    rom_addr_d = rom_addr_q;
    cnt_d      = cnt_q;
    a_ok_d     = 1'b0;
    a_data_d   = a_data_q;
    b_ok_d     = 1'b0;
    b_data_d   = b_data_q;
    tout_err_d = tout_err_q;
    a_wr       = 1'b0;
    b_wr       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (a_hit) begin
          a_ok_d   = 1'b1;
          a_data_d = a_cdata;
        end
        if (b_hit) begin
          b_ok_d   = 1'b1;
          b_data_d = b_cdata;
        end
        if (a_miss || b_miss) begin
          gnt_d      = pick;
          rr_last_d  = pick;
          rom_addr_d = (pick == SIDE_A) ? bus.a_addr : bus.b_addr;
          rom_cs_d   = 1'b1;
          cnt_d      = '0;
          state_d    = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (bus.rom_ok) begin
          rom_cs_d = 1'b0;
          state_d  = ST_GAP;
          // Cache fills even if the requester has since dropped req.
          if (gnt_q == SIDE_A) begin
            a_wr     = 1'b1;
            a_data_d = bus.rom_data;
            a_ok_d   = bus.a_req;
          end else begin
            b_wr     = 1'b1;
            b_data_d = bus.rom_data;
            b_ok_d   = bus.b_req;
          end
        end else if (cnt_q == CNT_LAST) begin
          // TOUT-th BUSY cycle without rom_ok: abort, return zero, no fill.
          rom_cs_d   = 1'b0;
          state_d    = ST_GAP;
          tout_err_d = 1'b1;
          if (gnt_q == SIDE_A) begin
            a_data_d = 8'h00;
            a_ok_d   = bus.a_req;
          end else begin
            b_data_d = 8'h00;
            b_ok_d   = bus.b_req;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_GAP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_last_q  <= SIDE_B;
      gnt_q      <= SIDE_A;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
      cnt_q      <= '0;
      a_ok_q     <= 1'b0;
      a_data_q   <= '0;
      b_ok_q     <= 1'b0;
      b_data_q   <= '0;
      tout_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      gnt_q      <= gnt_d;
      rom_cs_q   <= rom_cs_d;
      rom_addr_q <= rom_addr_d;
      cnt_q      <= cnt_d;
      a_ok_q     <= a_ok_d;
      a_data_q   <= a_data_d;
      b_ok_q     <= b_ok_d;
      b_data_q   <= b_data_d;
      tout_err_q <= tout_err_d;
    end
  end

  assign bus.a_ok     = a_ok_q;
  assign bus.a_data   = a_data_q;
  assign bus.b_ok     = b_ok_q;
  assign bus.b_data   = b_data_q;
  assign bus.rom_cs   = rom_cs_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.tout_err = tout_err_q;

endmodule

// File: tb/tb_jt10_adpcm_romarb.sv
// Directed bench for jt10_adpcm_romarb (AW=24, TOUT=15).
// ROM model: byte at address x is x[7:0] ^ x[15:8] ^ 8'hA5; rom_ok is raised
// rom_lat negedges after rom_cs is first seen high (rom_lat=0: never).
module tb_jt10_adpcm_romarb;

  logic clk;
  logic rst;

  jt10_adpcm_romarb_if #(.AW(24)) bus ();

  jt10_adpcm_romarb #(.AW(24), .TOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int a_ok_cnt = 0;
  int b_ok_cnt = 0;
  int cs_rise  = 0;
  int rom_lat  = 0;
  logic [23:0] rom_log[$];

  function automatic logic [7:0] rom_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // ROM responder and pulse monitor, both on the falling edge.
  initial begin : rom_model
    int   cyc;
    logic cs_prev;
    cyc          = 0;
    cs_prev      = 1'b0;
    bus.rom_ok   = 1'b0;
    bus.rom_data = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.rom_cs === 1'b1) begin
        if (!cs_prev) begin
          cs_rise++;
          rom_log.push_back(bus.rom_addr);
          cyc = 0;
        end
        cyc++;
        if (rom_lat != 0 && cyc == rom_lat) begin
          bus.rom_ok   = 1'b1;
          bus.rom_data = rom_byte(bus.rom_addr);
        end else begin
          bus.rom_ok = 1'b0;
        end
        cs_prev = 1'b1;
      end else begin
        bus.rom_ok = 1'b0;
        cyc        = 0;
        cs_prev    = 1'b0;
      end
      if (bus.a_ok === 1'b1) a_ok_cnt++;
      if (bus.b_ok === 1'b1) b_ok_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Cycles from now until a_ok is seen; -1 if the bound expires.
  task automatic wait_a(input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk);
      #1;
      if (bus.a_ok === 1'b1) begin
        cyc = i;
        return;
      end
    end
  endtask

  // Serve both requesters, dropping each req as its ok arrives.
  task automatic serve_both(input int max, output int ta, output int tbv,
                            output logic [7:0] da, output logic [7:0] db);
    ta = -1; tbv = -1; da = 8'h00; db = 8'h00;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk);
      #1;
      if (bus.a_ok === 1'b1 && ta < 0) begin
        ta = i; da = bus.a_data; bus.a_req = 1'b0;
      end
      if (bus.b_ok === 1'b1 && tbv < 0) begin
        tbv = i; db = bus.b_data; bus.b_req = 1'b0;
      end
      if (ta >= 0 && tbv >= 0) return;
    end
  endtask

  initial begin : stim
    int c, ta, tbv, s_cs, s_log, s_a;
    logic [7:0] da, db;

    rst = 1'b1;
    bus.a_req = 1'b0; bus.a_addr = '0;
    bus.b_req = 1'b0; bus.b_addr = '0;
    tick(2);

    // Reset state
    chk("rst_a_ok",     bus.a_ok,     0);
    chk("rst_a_data",   bus.a_data,   0);
    chk("rst_b_ok",     bus.b_ok,     0);
    chk("rst_b_data",   bus.b_data,   0);
    chk("rst_rom_cs",   bus.rom_cs,   0);
    chk("rst_rom_addr", bus.rom_addr, 0);
    chk("rst_tout_err", bus.tout_err, 0);
    rst = 1'b0;
    tick(1);

    // 1: A miss at 0x000100, ROM latency 3 -> 1 (grant) + 3 = 4 cycles
    s_cs = cs_rise; s_log = rom_log.size(); s_a = a_ok_cnt;
    rom_lat = 3;
    bus.a_addr = 24'h000100; bus.a_req = 1'b1;
    wait_a(20, c);
    chk("t1_latency", c, 4);
    chk("t1_data", bus.a_data, 8'hA4);
    bus.a_req = 1'b0;
    tick(3);
    chk("t1_ok_once", a_ok_cnt - s_a, 1);
    chk("t1_cs_pulses", cs_rise - s_cs, 1);
    chk("t1_rom_addr", rom_log[s_log], 24'h000100);

    // 2: re-request same addr -> hit in 1 cycle, no ROM access;
    //    req held through the ok cycle gives a second hit one cycle later
    bus.a_req = 1'b1;
    wait_a(5, c);
    chk("t2_latency", c, 1);
    chk("t2_data", bus.a_data, 8'hA4);
    chk("t2_rom_cs", bus.rom_cs, 0);
    tick(1);
    chk("t2_ok_gap", bus.a_ok, 0);
    tick(1);
    chk("t2_rehit", bus.a_ok, 1);
    bus.a_req = 1'b0;
    chk("t2_no_rom", cs_rise - s_cs, 1);

    // 3: from reset, A(0x10) and B(0x20) miss together -> A first
    rst = 1'b1; tick(2); rst = 1'b0; tick(1);
    s_cs = cs_rise; s_log = rom_log.size();
    rom_lat = 2;
    bus.a_addr = 24'h000010; bus.b_addr = 24'h000020;
    bus.a_req = 1'b1; bus.b_req = 1'b1;
    serve_both(40, ta, tbv, da, db);
    chk("t3_a_first", (ta >= 0 && ta < tbv), 1);
    chk("t3_a_data", da, 8'hB5);
    chk("t3_b_data", db, 8'h85);
    chk("t3_cs_pulses", cs_rise - s_cs, 2);
    chk("t3_rom_addr0", rom_log[s_log], 24'h000010);
    chk("t3_rom_addr1", rom_log[s_log + 1], 24'h000020);
    tick(2);

    // Solo A miss makes A the last grant, so the next tie must go to B
    bus.a_addr = 24'h000028; bus.a_req = 1'b1;
    wait_a(10, c);
    chk("t4_solo_data", bus.a_data, 8'h8D);
    bus.a_req = 1'b0;
    tick(2);

    // 4: both miss again (0x30, 0x40) -> B first
    s_cs = cs_rise; s_log = rom_log.size();
    bus.a_addr = 24'h000030; bus.b_addr = 24'h000040;
    bus.a_req = 1'b1; bus.b_req = 1'b1;
    serve_both(40, ta, tbv, da, db);
    chk("t4_b_first", (tbv >= 0 && tbv < ta), 1);
    chk("t4_a_data", da, 8'h95);
    chk("t4_b_data", db, 8'hE5);
    chk("t4_rom_addr0", rom_log[s_log], 24'h000040);
    chk("t4_rom_addr1", rom_log[s_log + 1], 24'h000030);
    tick(2);

    // 5: no rom_ok -> 15 BUSY cycles then abort; ok at 1 + 15 = 16
    chk("t5_err_pre", bus.tout_err, 0);
    s_cs = cs_rise;
    rom_lat = 0;
    bus.a_addr = 24'h000050; bus.a_req = 1'b1;
    wait_a(30, c);
    chk("t5_latency", c, 16);
    chk("t5_data_zero", bus.a_data, 8'h00);
    chk("t5_tout_err", bus.tout_err, 1);
    bus.a_req = 1'b0;
    tick(3);
    chk("t5_err_sticky", bus.tout_err, 1);
    rom_lat = 2;
    bus.a_req = 1'b1;
    wait_a(10, c);
    chk("t5_refetch_lat", c, 3);
    chk("t5_refetch_data", bus.a_data, 8'hF5);
    chk("t5_refetch_rom", cs_rise - s_cs, 2);
    chk("t5_err_still", bus.tout_err, 1);
    bus.a_req = 1'b0;
    tick(2);

    // 6: A drops req mid-BUSY -> no ok, but the cache is filled
    s_cs = cs_rise; s_a = a_ok_cnt;
    rom_lat = 3;
    bus.a_addr = 24'h000060; bus.a_req = 1'b1;
    tick(2);
    bus.a_req = 1'b0;
    tick(8);
    chk("t6_no_ok", a_ok_cnt - s_a, 0);
    chk("t6_one_fetch", cs_rise - s_cs, 1);
    bus.a_req = 1'b1;
    wait_a(5, c);
    chk("t6_hit_lat", c, 1);
    chk("t6_hit_data", bus.a_data, 8'hC5);
    chk("t6_hit_no_rom", cs_rise - s_cs, 1);
    bus.a_req = 1'b0;
    tick(2);

    // 7: reset mid-BUSY drops rom_cs, clears flags and caches
    s_cs = cs_rise;
    rom_lat = 0;
    bus.a_addr = 24'h000070; bus.a_req = 1'b1;
    tick(3);
    chk("t7_busy_cs", bus.rom_cs, 1);
    rst = 1'b1; bus.a_req = 1'b0;
    tick(1);
    chk("t7_rst_cs", bus.rom_cs, 0);
    chk("t7_rst_a_ok", bus.a_ok, 0);
    chk("t7_rst_b_ok", bus.b_ok, 0);
    chk("t7_rst_err", bus.tout_err, 0);
    rst = 1'b0;
    tick(1);
    rom_lat = 2;
    bus.a_addr = 24'h000060; bus.a_req = 1'b1;
    wait_a(10, c);
    chk("t7_miss_lat", c, 3);
    chk("t7_miss_data", bus.a_data, 8'hC5);
    chk("t7_miss_rom", cs_rise - s_cs, 2);
    bus.a_req = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
